// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with 2-entry skid buffer and flush.
// Optional performance counters (stall_cnt, flush_cnt) enabled by defining PIPE_STAGE_PERF_EN.
`default_nettype none

module pipe_stage_reg #(
    parameter int DATA_W = 133,
    parameter int CTRL_W = 9
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;

    logic                w_in_fire;
    logic                w_out_fire;

    // A payload offered during a flush cycle is dropped, so flush masks acceptance.
    assign w_in_fire  = in_valid & r_in_ready & ~flush;
    assign w_out_fire = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_main_ctrl <= in_ctrl;
                        r_main_data <= in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= HALF;
                    end
                end
                HALF: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire && w_out_fire) begin
                        r_main_ctrl <= in_ctrl;
                        r_main_data <= in_data;
                    end else if (w_in_fire) begin
                        r_skid_ctrl <= in_ctrl;
                        r_skid_data <= in_data;
                        r_in_ready  <= 1'b0;
                        r_state     <= FULL;
                    end else if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                FULL: begin
                    r_in_ready <= w_out_fire;
                    if (w_out_fire) begin
                        r_main_ctrl <= r_skid_ctrl;
                        r_main_data <= r_skid_data;
                        r_state     <= HALF;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_main_ctrl <= '0;
                    r_skid_ctrl <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    // Bubbles must never expose stale MEM/WB enables downstream.
    assign out_ctrl  = r_out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_out_valid && !out_ready) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush && (r_state != EMPTY)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed steps, queue of expected payloads.
`default_nettype none

module tb_pipe_stage_reg;

    localparam int DATA_W = 133;
    localparam int CTRL_W = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } item_t;

    item_t sb[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check status against the model at the negedge, update scoreboard, advance.
    task automatic cycle(output logic accepted);
        item_t exp_item;
        logic  of;
        @(negedge clk);
        chk("out_valid", 160'(out_valid), 160'(sb.size() != 0));
        chk("in_ready",  160'(in_ready),  160'(sb.size() != 2));
        if (!out_valid) chk("bubble_ctrl", 160'(out_ctrl), 160'(0));
        of       = out_valid & out_ready;
        accepted = in_valid & in_ready & ~flush;
        if (of) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 160'(out_data), 160'(0) - 160'(1));
            end else begin
                exp_item = sb.pop_front();
                chk("out_data", 160'(out_data), 160'(exp_item.data));
                chk("out_ctrl", 160'(out_ctrl), 160'(exp_item.ctrl));
            end
        end
        if (flush) sb.delete();
        else if (accepted) sb.push_back({in_ctrl, in_data});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(a);
    endtask

    task automatic send(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        logic a;
        int   k;
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        k = 0;
        a = 1'b0;
        while (!a && k < 20) begin
            cycle(a);
            k++;
        end
        if (!a) chk("send_timeout", 160'(0), 160'(1));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("drained", 160'(sb.size()), 160'(0));
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        chk("rst_in_ready",  160'(in_ready),  160'(0));
        chk("rst_out_ctrl",  160'(out_ctrl),  160'(0));
        chk("rst_out_data",  160'(out_data),  160'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 160'(in_ready), 160'(1));

        // Streaming 0x10..0x17
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(9'h1FF, DATA_W'(8'h10 + i));
        drain();

        // Backpressure: A2 held upstream while FULL
        out_ready = 1'b0;
        send(9'h011, DATA_W'(8'hA0));
        send(9'h022, DATA_W'(8'hA1));
        in_data = DATA_W'(8'hA2);
        in_ctrl = 9'h033;
        idle(2);
        chk("bp_in_ready", 160'(in_ready), 160'(0));
        out_ready = 1'b1;
        send(9'h033, DATA_W'(8'hA2));
        drain();

        // Flush in FULL with 0xB5 offered
        out_ready = 1'b0;
        send(9'h0F0, DATA_W'(8'hB0));
        send(9'h00F, DATA_W'(8'hB1));
        in_valid = 1'b1;
        in_data  = DATA_W'(8'hB5);
        in_ctrl  = 9'h1AA;
        flush    = 1'b1;
        idle(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 160'(out_valid), 160'(0));
        chk("fl_out_ctrl",  160'(out_ctrl),  160'(0));
        chk("fl_in_ready",  160'(in_ready),  160'(1));
        drain();

        // Bubble control
        out_ready = 1'b1;
        send(9'h1C3, DATA_W'(8'h55));
        in_valid = 1'b0;
        idle(3);
        chk("bub_ctrl", 160'(out_ctrl), 160'(0));

        // Async reset while FULL
        out_ready = 1'b0;
        send(9'h101, DATA_W'(8'hC0));
        send(9'h102, DATA_W'(8'hC1));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_out_valid", 160'(out_valid), 160'(0));
        chk("arst_out_ctrl",  160'(out_ctrl),  160'(0));
        chk("arst_out_data",  160'(out_data),  160'(0));
        chk("arst_in_ready",  160'(in_ready),  160'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arel_in_ready",  160'(in_ready),  160'(1));
        chk("arel_out_valid", 160'(out_valid), 160'(0));

`ifdef PIPE_STAGE_PERF_EN
        chk("perf_rst_stall", 160'(stall_cnt), 160'(0));
        chk("perf_rst_flush", 160'(flush_cnt), 160'(0));
        out_ready = 1'b0;
        send(9'h0AA, DATA_W'(8'hD0));
        in_valid = 1'b0;
        idle(5);
        out_ready = 1'b1;
        flush     = 1'b1;
        idle(1);
        flush     = 1'b0;
        chk("perf_stall", 160'(stall_cnt), 160'(5));
        chk("perf_flush", 160'(flush_cnt), 160'(1));
`endif
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
